// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: op encodings, the op field
// width, and helpers for stage count and operand preparation.
package adder_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_ADC = 2'd2;
    localparam logic [OP_W-1:0] OP_SBC = 2'd3;

    // Number of CHUNK-bit slices; guarded so a bad CHUNK never divides by zero
    // before the elaboration check in the top level can report it.
    function automatic int num_stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    // Subtraction is A + ~B + c0, so the B operand is inverted for SUB/SBC.
    function automatic logic op_inverts_b(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // Carry into bit 0. For SBC, cin=1 means "no borrow pending".
    function automatic logic op_carry_in(input logic [OP_W-1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the ripple pipeline: adds its operand slice with the
// incoming carry and registers sum, carry-out and a running "all result bits
// so far are zero" flag. Everything holds when en is low.
module adder_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    input  logic             z_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             z_out
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

    // Stage register: load the slice result when the pipeline advances.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum   <= '0;
            c_out <= 1'b0;
            z_out <= 1'b0;
        end else if (en) begin
            sum   <= total[CHUNK-1:0];
            c_out <= total[CHUNK];
            z_out <= z_in && (total[CHUNK-1:0] == '0);
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor with ALU flags. An input register captures the
// prepared operands; then one adder_stage per CHUNK-bit slice ripples the
// carry, so a beat emerges STAGES cycles after acceptance. Each stage carries
// only the operand bits still to be consumed and the result bits already
// produced. A single global stall freezes every register, bubbles included.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [OP_W-1:0]  op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_params
        $fatal(1, "pipelined_adder: WIDTH must be a non-zero multiple of a non-zero CHUNK");
    end

    logic             stall;
    logic             adv;
    logic             accept;
    logic             v_r;
    logic             c0_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sign_a;
    logic             sign_b;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Input register: prepare B' and c0 once, at acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_r  <= 1'b0;
            c0_r <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
        end else if (adv) begin
            v_r <= accept;
            if (accept) begin
                a_r  <= in0;
                b_r  <= op_inverts_b(op) ? ~in1 : in1;
                c0_r <= op_carry_in(op, cin);
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int REM = WIDTH - k * CHUNK;

        logic [REM-1:0]         a_cur;
        logic [REM-1:0]         b_cur;
        logic                   c_in;
        logic                   z_in;
        logic                   v_q;
        logic [CHUNK-1:0]       sum;
        logic                   c_out;
        logic                   z_out;
        logic [(k+1)*CHUNK-1:0] res;

        if (k == 0) begin : g_first
            assign a_cur = a_r;
            assign b_cur = b_r;
            assign c_in  = c0_r;
            assign z_in  = 1'b1;
            assign res   = sum;

            // Stage valid bit follows the input register.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_r;
                end
            end
        end else begin : g_next
            logic [k*CHUNK-1:0] lo;

            assign c_in = g_st[k-1].c_out;
            assign z_in = g_st[k-1].z_out;
            assign res  = {sum, lo};

            // Pass unconsumed operand bits and finished low result bits down.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    v_q   <= 1'b0;
                    a_cur <= '0;
                    b_cur <= '0;
                    lo    <= '0;
                end else if (adv) begin
                    v_q   <= g_st[k-1].v_q;
                    a_cur <= g_st[k-1].a_cur[REM+CHUNK-1:CHUNK];
                    b_cur <= g_st[k-1].b_cur[REM+CHUNK-1:CHUNK];
                    lo    <= g_st[k-1].res;
                end
            end
        end

        adder_stage #(.CHUNK(CHUNK)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (adv),
            .a       (a_cur[CHUNK-1:0]),
            .b       (b_cur[CHUNK-1:0]),
            .c_in    (c_in),
            .z_in    (z_in),
            .sum     (sum),
            .c_out   (c_out),
            .z_out   (z_out)
        );
    end

    // Operand signs at the top slice, kept alongside the final sum so that
    // overflow (same-sign operands, different-sign result) stays aligned.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (adv) begin
            sign_a <= g_st[STAGES-1].a_cur[CHUNK-1];
            sign_b <= g_st[STAGES-1].b_cur[CHUNK-1];
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign out       = g_st[STAGES-1].res;
    assign carry     = g_st[STAGES-1].c_out;
    assign zero      = g_st[STAGES-1].z_out;
    assign negative  = out[WIDTH-1];
    assign overflow  = (sign_a == sign_b) && (out[WIDTH-1] != sign_a);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4): directed
// vectors, latency, backpressure, mid-stream reset, and a randomized stream
// scored against an arithmetic reference model.
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in0 = '0;
    logic [W-1:0]  in1 = '0;
    logic [1:0]    op = 2'd0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out;
    logic          carry, overflow, zero, negative;

    int   tests = 0;
    int   fails = 0;
    int   delivered = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    // Reference: exact integer arithmetic, then reduce to W bits and flags.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] o, input logic ci);
        longint ua, ub, sa, sb, iu, is;
        logic   is_sub;
        exp_t   e;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        is_sub = (o == OP_SUB) || (o == OP_SBC);
        case (o)
            OP_ADD:  begin iu = ua + ub;                   is = sa + sb;                   end
            OP_SUB:  begin iu = ua - ub;                   is = sa - sb;                   end
            OP_ADC:  begin iu = ua + ub + longint'(ci);    is = sa + sb + longint'(ci);    end
            default: begin iu = ua - ub - longint'(!ci);   is = sa - sb - longint'(!ci);   end
        endcase
        e.res = iu[W-1:0];
        e.c   = is_sub ? (iu >= 0) : (iu >= (longint'(1) << W));
        e.v   = (is < -(longint'(1) << (W-1))) || (is > (longint'(1) << (W-1)) - 1);
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        return e;
    endfunction

    // Scoreboard: record accepts and check every transfer in order.
    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            q.push_back(model(in0, in1, op, cin));
        end
        if (reset_n && out_valid && out_ready) begin
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_beat got out=%h with no beat outstanding", out);
            end
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                delivered++;
                tests++;
                assert ({out, carry, overflow, zero, negative} === mon_e) else begin
                    fails++;
                    $error("FAIL scoreboard got out=%h c=%b v=%b z=%b n=%b exp out=%h c=%b v=%b z=%b n=%b",
                           out, carry, overflow, zero, negative,
                           mon_e.res, mon_e.c, mon_e.v, mon_e.z, mon_e.n);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out"},       32'(out),       32'd0);
        chk({tag, "_flags"},     32'({carry, overflow, zero, negative}), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Single beat, wait (bounded) for its result, check against constants.
    task automatic one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] o, input logic ci, input logic [W-1:0] eo,
                       input logic ec, input logic ev, input logic ez, input logic en);
        in0 = a; in1 = b; op = o; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"},   32'(out),       32'(eo));
        chk({tag, "_flags"}, 32'({carry, overflow, zero, negative}), 32'({ec, ev, ez, en}));
        step();
    endtask

    // Accept one beat and check out_valid rises exactly STAGES edges later.
    task automatic latency(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eo);
        in0 = a; in1 = b; op = OP_ADD; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat0"}, 32'(out_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("%s_lat%0d", tag, i), 32'(out_valid), 32'(i == 4));
        end
        chk({tag, "_out"}, 32'(out), 32'(eo));
        step();
    endtask

    int             sent;
    int             d0;
    logic [W+3:0]   held;

    initial begin
        reset_n = 1'b0;
        step();
        step();
        chk_reset_state("reset");
        reset_n = 1'b1;
        step();

        latency("add_2536_113", 16'd2536, 16'd113, 16'd2649);
        chk("add_2536_113_flags", 32'({carry, overflow, zero}), 32'd0);

        one("sub_100_200", 16'd100,  16'd200, OP_SUB, 1'b0, 16'hFF9C, 1'b0, 1'b0, 1'b0, 1'b1);
        one("sub_200_100", 16'd200,  16'd100, OP_SUB, 1'b0, 16'd100,  1'b1, 1'b0, 1'b0, 1'b0);
        one("add_7fff_1",  16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        one("add_ffff_1",  16'hFFFF, 16'h0001, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        one("adc_ffff_0",  16'hFFFF, 16'h0000, OP_ADC, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        one("sbc_5_3",     16'd5,    16'd3,    OP_SBC, 1'b0, 16'd1,    1'b1, 1'b0, 1'b0, 1'b0);
        one("add_cin_ign", 16'd7,    16'd8,    OP_ADD, 1'b1, 16'd15,   1'b0, 1'b0, 1'b0, 1'b0);
        one("sub_8000_1",  16'h8000, 16'h0001, OP_SUB, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Backpressure: six beats, consumer not ready for cycles 3..8.
        d0 = delivered;
        sent = 0;
        held = '0;
        for (int c = 0; c < 40 && (sent < 6 || q.size() != 0); c++) begin
            out_ready = !(c >= 3 && c <= 8);
            in_valid  = (sent < 6);
            in0 = W'(sent + 1000); in1 = W'(sent); op = OP_ADD; cin = 1'b0;
            #1;
            if (c >= 5 && c <= 8) begin
                chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
                chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
                if (c == 5) held = {out, carry, overflow, zero, negative};
                else chk($sformatf("bp_hold_c%0d", c), 32'({out, carry, overflow, zero, negative}), 32'(held));
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_delivered", 32'(delivered - d0), 32'd6);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            in0 = W'($urandom); in1 = W'($urandom); op = OP_ADD; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        q.delete();
        step();
        chk_reset_state("midreset");
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("no_stale_%0d", i), 32'(out_valid), 32'd0);
        end
        latency("post_reset_1_1", 16'd1, 16'd1, 16'd2);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            in1 = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
            op  = 2'($urandom_range(0, 3));
            cin = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined integer adder/subtractor for the emulator datapath library.
- Successor to the fixed 16-bit combinational adder: operand width and pipeline depth are configurable, four operations are supported, and it produces ALU-style flags.
- Carry ripples through CHUNK-bit slices, one slice per stage, so timing closes at any WIDTH.
- Valid/ready handshake on both sides with full backpressure; feeds the ALU result mux and flag register.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (default 4).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in0  in  WIDTH  operand A.
- in1  in  WIDTH  operand B.
- op  in  2  operation: ADD=0, SUB=1, ADC=2, SBC=3.
- cin  in  1  carry-in; used by ADC/SBC only.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- carry  out  1  carry out of the MSB. For SUB/SBC, 1 means no borrow.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  out == 0.
- negative  out  1  out[WIDTH-1].

Behaviour:
- Reset is synchronous and active-low. While reset_n==0 at a rising edge:
  - all stage valid bits clear; out_valid=0.
  - out, carry, overflow, zero, negative = 0.
  - in_ready is combinational (see handshake) and therefore reads 1 once stages are empty.
- Reset mid-operation discards every in-flight beat; no partial result is ever presented.
- Operand preparation at acceptance:
  - B' = in1 for ADD/ADC; ~in1 for SUB/SBC.
  - c0 = 0 for ADD; 1 for SUB; cin for ADC; cin for SBC (cin=1 means no borrow).
- Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] from the registered A, B' and the carry from stage k-1 (c0 for k=0).
  - Stage k registers that sum slice, its carry-out, the not-yet-used upper operand bits, and the already-computed lower result bits.
- Final-stage flags:
  - carry = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero and negative are derived from the full registered result.
- Latency: a beat accepted at edge N has out_valid=1 after edge N+STAGES, provided there is no stall. Throughput is one beat per cycle.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready. While stalled, every stage holds, and out and the flags are held stable.
  - in_ready = !stall. Bubbles are not compressed.
  - When not stalled, every stage advances, including stages holding bubbles.
  - in0, in1, op and cin are sampled only on accept; their values at other times are don't-care.
- Simultaneous output transfer and input accept in the same cycle is legal and sustains full rate.
- Wrap-around is modulo 2^WIDTH; the lost bit appears only in carry.
- Invalid parameters (WIDTH % CHUNK != 0, or CHUNK == 0) trigger an elaboration-time $fatal.

Decomposition:
- Package adder_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_ADC, OP_SBC;
  - the op width constant (2);
  - a helper function computing STAGES.
- One sub-module, adder_stage (parameter CHUNK): a CHUNK-bit slice adder plus its stage register with hold enable, instantiated STAGES times by a generate loop.
- Handshake and stall logic live in the top level.

Test Plan:
- ADD 2536+113, WIDTH=16, CHUNK=4, out_ready=1 -> out=2649, carry=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept.
- SUB 100-200 -> out=0xFF9C, carry=0, negative=1, overflow=0. SUB 200-100 -> out=100, carry=1.
- ADD 0x7FFF+0x0001 -> out=0x8000, overflow=1, negative=1, carry=0. ADD 0xFFFF+0x0001 -> out=0, carry=1, zero=1, overflow=0.
- ADC chain: 0xFFFF+0x0000 with cin=1 -> out=0, carry=1. SBC 5-3 with cin=0 -> out=1, carry=1.
- Backpressure: stream 6 beats (i+1000)+i with out_ready low for cycles 3..8 -> in_ready low while stalled, out and flags stable, all 6 results delivered in order with no loss or duplication.
- Reset mid-stream: 3 beats in flight, then reset_n=0 for 1 cycle -> out_valid=0 and all outputs 0 next cycle; no stale beat emerges; the next beat 1+1 returns 2 after 4 cycles.
